mem_port_arbiter: RTL and testbench

Sequential arbiter that shares one single-port unified memory between the instruction-fetch requester and the data (load/store) requester of the RV32I pipeline. It accepts held-request/ready-pulse handshakes from both sides and grants one access at a time with data-side priority. It drives the memory enable, read/write and byte-mask controls for a fixed-latency array. It sits between the fetch/mem-stage pipeline registers and the memory model, and exports per-side wait signals that the stall logic ORs in.

---
 rtl/mem_port_arbiter_if.sv | 37 +++
 rtl/mem_port_arbiter.sv | 75 +++++++
 tb/tb_mem_port_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side buses of the unified memory arbiter.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic [DW-1:0]   if_rdata;
  logic            if_ready;
  logic            if_wait;
  logic            dm_req;
  logic            dm_we;
  logic [DW/8-1:0] dm_mask;
  logic [AW-1:0]   dm_addr;
  logic [DW-1:0]   dm_wdata;
  logic [DW-1:0]   dm_rdata;
  logic            dm_ready;
  logic            dm_wait;
  logic            mem_en;
  logic            mem_rw;
  logic [DW/8-1:0] mem_mask;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            busy;
  logic            gnt_dm;
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_mask, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ready, if_wait, dm_rdata, dm_ready, dm_wait,
    input  mem_en, mem_rw, mem_mask, mem_addr, mem_wdata, busy, gnt_dm
  );
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_mask, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ready, if_wait, dm_rdata, dm_ready, dm_wait,
    output mem_en, mem_rw, mem_mask, mem_addr, mem_wdata, busy, gnt_dm
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory between fetch and data requesters, data first.
// Define ARB_STARVE_GUARD_EN to let fetch win after MAX_DSTREAK data grants made while it waited.
module mem_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MEM_LAT     = 1,
  parameter int MAX_DSTREAK = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t     r_state, w_next;
  logic [3:0] r_cnt;
  logic       w_grant, w_done, w_pick_dm;
  if (MEM_LAT < 1 || MEM_LAT > 15 || MAX_DSTREAK < 1 || MAX_DSTREAK > 15)
    $error("mem_port_arbiter: MEM_LAT and MAX_DSTREAK must be in 1..15");
`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] r_streak;
  assign w_pick_dm = bus.dm_req && !(bus.if_req && r_streak >= 4'(MAX_DSTREAK));
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_streak <= 4'd0;
    else if (w_grant) r_streak <= (w_pick_dm && bus.if_req) ? r_streak + 4'd1 : 4'd0;
`else
  assign w_pick_dm = bus.dm_req;
`endif
  always_comb begin
    w_grant = (r_state == IDLE) && (bus.if_req || bus.dm_req);
    w_done  = (r_state == ACCESS) && (r_cnt == 4'd1);
    w_next  = w_grant ? ACCESS : w_done ? RESP : (r_state == RESP) ? IDLE : r_state;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_cnt         <= 4'd0;
      bus.mem_en    <= 1'b0;
      bus.mem_rw    <= 1'b0;
      bus.mem_mask  <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_rdata  <= '0;
      bus.dm_rdata  <= '0;
      bus.if_ready  <= 1'b0;
      bus.dm_ready  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.gnt_dm    <= 1'b0;
    end else begin
      bus.if_ready <= 1'b0;
      bus.dm_ready <= 1'b0;
      if (w_grant) begin
        r_cnt         <= 4'(MEM_LAT);
        bus.busy      <= 1'b1;
        bus.gnt_dm    <= w_pick_dm;
        bus.mem_en    <= 1'b1;
        bus.mem_rw    <= w_pick_dm ? ~bus.dm_we : 1'b1;
        bus.mem_mask  <= w_pick_dm ? bus.dm_mask : {DW/8{1'b1}};
        bus.mem_addr  <= w_pick_dm ? bus.dm_addr : bus.if_addr;
        bus.mem_wdata <= w_pick_dm ? bus.dm_wdata : {DW{1'b0}};
      end else if (r_state == ACCESS) begin
        r_cnt <= r_cnt - 4'd1;
        if (w_done) begin
          bus.mem_en   <= 1'b0;
          bus.if_ready <= ~bus.gnt_dm;
          bus.dm_ready <= bus.gnt_dm;
          if (!bus.gnt_dm) bus.if_rdata <= bus.mem_rdata;
          if (bus.gnt_dm && bus.mem_rw) bus.dm_rdata <= bus.mem_rdata;
        end
      end else if (r_state == RESP) bus.busy <= 1'b0;
    end
  assign bus.if_wait = bus.if_req && !bus.if_ready;
  assign bus.dm_wait = bus.dm_req && !bus.dm_ready;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int LAT  = 2;
  localparam int MAXD = 4;
  localparam int P    = LAT + 2;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset;
  int          vecs = 0;
  int          errs = 0;
  logic [31:0] dmem [256];
  logic [31:0] ref_mem [256];
  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();
  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT), .MAX_DSTREAK(MAXD)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] init_word(int i);
    return (i == 64) ? 32'h00500093 : 32'hA5A50000 ^ (32'(i) * 32'h01010101);
  endfunction
  // memory device: contents restored while reset is low, byte-masked writes while enabled
  assign bus.mem_rdata = dmem[bus.mem_addr[9:2]];
  always @(posedge clk)
    if (!reset) for (int i = 0; i < 256; i++) dmem[i] <= init_word(i);
    else if (bus.mem_en && !bus.mem_rw)
      for (int b = 0; b < 4; b++) if (bus.mem_mask[b]) dmem[bus.mem_addr[9:2]][8*b+:8] <= bus.mem_wdata[8*b+:8];
  task automatic idle_inputs;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_mask = '0; bus.dm_addr = '0; bus.dm_wdata = '0;
  endtask
  task automatic do_reset;
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic test_reset;
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    vecs++; if ({bus.mem_en, bus.mem_rw, bus.mem_mask} !== 6'b0) begin errs++; $display("FAIL rst_memctl: got %b want 000000", {bus.mem_en, bus.mem_rw, bus.mem_mask}); end
    vecs++; if (bus.mem_addr !== 32'h0) begin errs++; $display("FAIL rst_addr: got %h want 0", bus.mem_addr); end
    vecs++; if ({bus.if_ready, bus.dm_ready, bus.busy, bus.gnt_dm} !== 4'b0) begin errs++; $display("FAIL rst_flags: got %b want 0000", {bus.if_ready, bus.dm_ready, bus.busy, bus.gnt_dm}); end
    vecs++; if ({bus.if_rdata, bus.dm_rdata} !== 64'h0) begin errs++; $display("FAIL rst_rdata: got %h want 0", {bus.if_rdata, bus.dm_rdata}); end
    reset = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    @(negedge clk);
    vecs++; if ({bus.mem_en, bus.busy} !== 2'b11) begin errs++; $display("FAIL rst_first_grant: got %b want 11", {bus.mem_en, bus.busy}); end
    reset = 1'b0;
    bus.if_req = 1'b0;
    #1;
    vecs++; if ({bus.mem_en, bus.busy, bus.if_ready, bus.gnt_dm} !== 4'b0) begin errs++; $display("FAIL rst_async: got %b want 0000", {bus.mem_en, bus.busy, bus.if_ready, bus.gnt_dm}); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      vecs++; if ({bus.if_ready, bus.dm_ready, bus.mem_en} !== 3'b0) begin errs++; $display("FAIL rst_no_pulse[%0d]: got %b want 000", i, {bus.if_ready, bus.dm_ready, bus.mem_en}); end
    end
  endtask
  task automatic test_fetch;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    for (int i = 0; i <= LAT + 1; i++) begin
      @(negedge clk);
      vecs++; if (bus.mem_en !== (i < LAT)) begin errs++; $display("FAIL fetch_en[%0d]: got %b want %b", i, bus.mem_en, i < LAT); end
      if (i < LAT) begin
        vecs++; if ({bus.mem_rw, bus.mem_mask, bus.mem_addr} !== {1'b1, 4'hF, 32'h100}) begin errs++; $display("FAIL fetch_ctl[%0d]: got %b/%h/%h want 1/f/00000100", i, bus.mem_rw, bus.mem_mask, bus.mem_addr); end
      end
      vecs++; if (bus.if_ready !== (i == LAT)) begin errs++; $display("FAIL fetch_ready[%0d]: got %b want %b", i, bus.if_ready, i == LAT); end
      vecs++; if (bus.if_wait !== (i < LAT)) begin errs++; $display("FAIL fetch_wait[%0d]: got %b want %b", i, bus.if_wait, i < LAT); end
      if (i == LAT) begin
        vecs++; if (bus.if_rdata !== 32'h00500093) begin errs++; $display("FAIL fetch_rdata: got %h want 00500093", bus.if_rdata); end
        bus.if_req = 1'b0;
      end
    end
  endtask
  task automatic test_store;
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_mask = 4'b0011; bus.dm_addr = 32'h2000; bus.dm_wdata = 32'hDEADBEEF;
    for (int i = 0; i <= LAT + 1; i++) begin
      @(negedge clk);
      vecs++; if (bus.mem_en !== (i < LAT)) begin errs++; $display("FAIL store_en[%0d]: got %b want %b", i, bus.mem_en, i < LAT); end
      if (i < LAT) begin
        vecs++; if ({bus.mem_rw, bus.mem_mask, bus.mem_addr, bus.mem_wdata} !== {1'b0, 4'b0011, 32'h2000, 32'hDEADBEEF}) begin errs++; $display("FAIL store_ctl[%0d]: got %b/%h/%h/%h want 0/3/00002000/deadbeef", i, bus.mem_rw, bus.mem_mask, bus.mem_addr, bus.mem_wdata); end
        vecs++; if (bus.gnt_dm !== 1'b1) begin errs++; $display("FAIL store_gnt[%0d]: got %b want 1", i, bus.gnt_dm); end
      end
      vecs++; if ({bus.dm_ready, bus.if_ready} !== {i == LAT, 1'b0}) begin errs++; $display("FAIL store_ready[%0d]: got %b want %b0", i, {bus.dm_ready, bus.if_ready}, i == LAT); end
      vecs++; if (bus.dm_rdata !== 32'h0) begin errs++; $display("FAIL store_rdata[%0d]: got %h want 0", i, bus.dm_rdata); end
      if (i == LAT) bus.dm_req = 1'b0;
    end
  endtask
  task automatic test_simultaneous;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_mask = 4'hF; bus.dm_addr = 32'h40;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    for (int i = 0; i <= 2 * LAT + 3; i++) begin
      @(negedge clk);
      vecs++; if (bus.mem_en !== ((i < LAT) || (i >= LAT + 2 && i < 2 * LAT + 2))) begin errs++; $display("FAIL sim_en[%0d]: got %b", i, bus.mem_en); end
      vecs++; if (bus.gnt_dm !== (i < LAT + 2)) begin errs++; $display("FAIL sim_gnt[%0d]: got %b want %b", i, bus.gnt_dm, i < LAT + 2); end
      vecs++; if ({bus.dm_ready, bus.if_ready} !== {i == LAT, i == 2 * LAT + 2}) begin errs++; $display("FAIL sim_ready[%0d]: got %b", i, {bus.dm_ready, bus.if_ready}); end
      vecs++; if (bus.if_wait !== (i < 2 * LAT + 2)) begin errs++; $display("FAIL sim_if_wait[%0d]: got %b want %b", i, bus.if_wait, i < 2 * LAT + 2); end
      if (i == LAT) begin
        vecs++; if (bus.dm_rdata !== init_word(16)) begin errs++; $display("FAIL sim_dm_rdata: got %h want %h", bus.dm_rdata, init_word(16)); end
        bus.dm_req = 1'b0;
      end
      if (i == 2 * LAT + 2) begin
        vecs++; if (bus.if_rdata !== 32'h00500093) begin errs++; $display("FAIL sim_if_rdata: got %h want 00500093", bus.if_rdata); end
        bus.if_req = 1'b0;
      end
    end
  endtask
  task automatic test_streak;
    bit exp_d;
    do_reset();
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_mask = 4'hF; bus.dm_addr = 32'h80;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    for (int i = 0; i < 10 * P; i++) begin
      @(negedge clk);
      exp_d = GUARD ? ((i / P) % 5 != 4) : 1'b1;
      if (i % P == 0) begin
        vecs++; if ({bus.mem_en, bus.gnt_dm} !== {1'b1, exp_d}) begin errs++; $display("FAIL streak_grant[%0d]: got en/gnt_dm %b want 1%b", i / P, {bus.mem_en, bus.gnt_dm}, exp_d); end
      end
      if (i % P == LAT) begin
        vecs++; if ({bus.dm_ready, bus.if_ready} !== {exp_d, !exp_d}) begin errs++; $display("FAIL streak_ready[%0d]: got %b want %b%b", i / P, {bus.dm_ready, bus.if_ready}, exp_d, !exp_d); end
      end
    end
    idle_inputs();
    repeat (P) @(negedge clk);
  endtask
  task automatic test_random;
    int free_at = 0, g = -100, streak = 0, idx;
    bit gw_d = 1'b0, g_rw = 1'b0, exp_gnt = 1'b0, en_e, rdy;
    logic [31:0] g_addr = '0, g_wdata = '0, g_data = '0, exp_if = '0, exp_dm = '0;
    logic [3:0] g_mask = '0;
    do_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    for (int k = 0; k < 600; k++) begin
      if (k >= free_at && (bus.if_req || bus.dm_req)) begin
        gw_d    = bus.dm_req && !(GUARD && bus.if_req && streak >= MAXD);
        streak  = (gw_d && bus.if_req) ? streak + 1 : 0;
        g       = k;
        free_at = k + LAT + 2;
        exp_gnt = gw_d;
        g_addr  = gw_d ? bus.dm_addr : bus.if_addr;
        g_rw    = gw_d ? !bus.dm_we : 1'b1;
        g_mask  = gw_d ? bus.dm_mask : 4'hF;
        g_wdata = bus.dm_wdata;
        idx     = int'(g_addr[9:2]);
        g_data  = ref_mem[idx];
        if (!g_rw) for (int b = 0; b < 4; b++) if (g_mask[b]) ref_mem[idx][8*b+:8] = g_wdata[8*b+:8];
      end
      @(negedge clk);
      en_e = (k >= g) && (k < g + LAT);
      rdy  = (k == g + LAT);
      if (rdy && !gw_d) exp_if = g_data;
      if (rdy && gw_d && g_rw) exp_dm = g_data;
      vecs++; if (bus.mem_en !== en_e) begin errs++; $display("FAIL rnd_en[%0d]: got %b want %b", k, bus.mem_en, en_e); end
      vecs++; if (bus.busy !== (k >= g && k <= g + LAT)) begin errs++; $display("FAIL rnd_busy[%0d]: got %b", k, bus.busy); end
      vecs++; if ({bus.if_ready, bus.dm_ready} !== {rdy && !gw_d, rdy && gw_d}) begin errs++; $display("FAIL rnd_ready[%0d]: got %b want %b%b", k, {bus.if_ready, bus.dm_ready}, rdy && !gw_d, rdy && gw_d); end
      vecs++; if (bus.gnt_dm !== exp_gnt) begin errs++; $display("FAIL rnd_gnt[%0d]: got %b want %b", k, bus.gnt_dm, exp_gnt); end
      vecs++; if ({bus.if_wait, bus.dm_wait} !== {bus.if_req && !(rdy && !gw_d), bus.dm_req && !(rdy && gw_d)}) begin errs++; $display("FAIL rnd_wait[%0d]: got %b", k, {bus.if_wait, bus.dm_wait}); end
      vecs++; if (bus.if_rdata !== exp_if) begin errs++; $display("FAIL rnd_if_rdata[%0d]: got %h want %h", k, bus.if_rdata, exp_if); end
      vecs++; if (bus.dm_rdata !== exp_dm) begin errs++; $display("FAIL rnd_dm_rdata[%0d]: got %h want %h", k, bus.dm_rdata, exp_dm); end
      if (en_e) begin
        vecs++; if ({bus.mem_addr, bus.mem_rw, bus.mem_mask} !== {g_addr, g_rw, g_mask}) begin errs++; $display("FAIL rnd_memctl[%0d]: got %h/%b/%h want %h/%b/%h", k, bus.mem_addr, bus.mem_rw, bus.mem_mask, g_addr, g_rw, g_mask); end
        if (!g_rw) begin
          vecs++; if (bus.mem_wdata !== g_wdata) begin errs++; $display("FAIL rnd_wdata[%0d]: got %h want %h", k, bus.mem_wdata, g_wdata); end
        end
      end
      if (rdy && gw_d) bus.dm_req = 1'b0;
      if (rdy && !gw_d) bus.if_req = 1'b0;
      if (!bus.if_req && $urandom_range(0, 2) == 0) begin
        bus.if_req = 1'b1; bus.if_addr = 32'($urandom_range(0, 15)) << 2;
      end
      if (!bus.dm_req && $urandom_range(0, 2) == 0) begin
        bus.dm_req = 1'b1; bus.dm_we = 1'($urandom_range(0, 1)); bus.dm_mask = 4'($urandom_range(1, 15));
        bus.dm_addr = 32'($urandom_range(0, 15)) << 2; bus.dm_wdata = $urandom;
      end
    end
    idle_inputs();
    repeat (P) @(negedge clk);
  endtask
  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_fetch();
    test_store();
    test_simultaneous();
    test_streak();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
